// File: rtl/decoder.sv
// rtl/decoder.sv - instruction decoder for the 8-bit core
module decoder #(
    parameter int DataWidth         = 8,
    parameter int SEL_WIDTH         = 2,
    parameter int PROGRAM_DataWidth = 16,
    parameter int NumOpCodeBits     = 5,
    parameter int ParamBits         = 8,
    parameter int NumStatusBits     = 6,
    parameter int OP1_BIT_POS       = 9,
    parameter int OP2_BIT_POS       = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [PROGRAM_DataWidth-1:0] instruction,
    input  logic [NumStatusBits-1:0]     status,
    output logic [NumOpCodeBits-1:0]     opcode,
    output logic [ParamBits-1:0]         param,
    output logic [DataWidth-1:0]         literal_adr,
    output logic [SEL_WIDTH-1:0]         rd_sel1,
    output logic [SEL_WIDTH-1:0]         rd_sel2,
    output logic                         rd_en1,
    output logic                         rd_en2,
    output logic [SEL_WIDTH-1:0]         wr_sel,
    output logic                         wr_en,
    output logic                         sel_reg_in_alu_decoder,
    output logic                         cnt_wr_en,
    output logic                         add_offset,
    output logic                         stat_wr_en,
    output logic                         stat_reg_in_alu_decoder,
    output logic [NumStatusBits-1:0]     status_out,
    output logic                         illegal_op
);

    localparam logic [4:0] OP_NOP  = 5'h00;
    localparam logic [4:0] OP_ADD  = 5'h01;
    localparam logic [4:0] OP_SUB  = 5'h02;
    localparam logic [4:0] OP_AND  = 5'h03;
    localparam logic [4:0] OP_OR   = 5'h04;
    localparam logic [4:0] OP_NOT  = 5'h05;
    localparam logic [4:0] OP_XOR  = 5'h06;
    localparam logic [4:0] OP_SHL  = 5'h07;
    localparam logic [4:0] OP_SHR  = 5'h08;
    localparam logic [4:0] OP_VAL  = 5'h09;
    localparam logic [4:0] OP_CMP  = 5'h0A;
    localparam logic [4:0] OP_GOTO = 5'h10;
    localparam logic [4:0] OP_IFZ  = 5'h11;
    localparam logic [4:0] OP_IFNZ = 5'h12;
    localparam logic [4:0] OP_IFEQ = 5'h13;
    localparam logic [4:0] OP_IFST = 5'h14;
    localparam logic [4:0] OP_IFGT = 5'h15;

    logic [SEL_WIDTH-1:0] op1;
    logic [SEL_WIDTH-1:0] op2;
    logic rd_en1_d, rd_en2_d, wr_en_d, cnt_wr_en_d, add_offset_d, stat_wr_en_d;
    logic reserved;
    logic unused_bits;

    assign opcode      = instruction[PROGRAM_DataWidth-1 -: NumOpCodeBits];
    assign param       = instruction[ParamBits-1:0];
    assign literal_adr = instruction[DataWidth-1:0];
    assign op1         = instruction[OP1_BIT_POS -: SEL_WIDTH];
    assign op2         = instruction[OP2_BIT_POS -: SEL_WIDTH];
    assign unused_bits = &{1'b0, instruction[10], status[1:0]};

    assign stat_reg_in_alu_decoder = 1'b1;
    assign status_out              = '0;

    always_comb begin
        rd_sel1                = '0;
        rd_sel2                = '0;
        rd_en1_d               = 1'b0;
        rd_en2_d               = 1'b0;
        wr_sel                 = '0;
        wr_en_d                = 1'b0;
        sel_reg_in_alu_decoder = 1'b0;
        cnt_wr_en_d            = 1'b0;
        add_offset_d           = 1'b0;
        stat_wr_en_d           = 1'b0;
        reserved               = 1'b0;
        case (opcode)
            OP_NOP: ;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                rd_sel1 = op1; rd_sel2 = op2; rd_en1_d = 1'b1; rd_en2_d = 1'b1;
                wr_sel = op1; wr_en_d = 1'b1; sel_reg_in_alu_decoder = 1'b1; stat_wr_en_d = 1'b1;
            end
            OP_NOT: begin
                rd_sel2 = op2; rd_en2_d = 1'b1;
                wr_sel = op1; wr_en_d = 1'b1; sel_reg_in_alu_decoder = 1'b1; stat_wr_en_d = 1'b1;
            end
            OP_SHL, OP_SHR: begin
                rd_sel1 = op1; rd_en1_d = 1'b1;
                wr_sel = op1; wr_en_d = 1'b1; sel_reg_in_alu_decoder = 1'b1; stat_wr_en_d = 1'b1;
            end
            OP_VAL: begin
                wr_sel = op1; wr_en_d = 1'b1;
            end
            OP_CMP: begin
                rd_sel1 = op1; rd_sel2 = op2; rd_en1_d = 1'b1; rd_en2_d = 1'b1; stat_wr_en_d = 1'b1;
            end
            OP_GOTO: cnt_wr_en_d = 1'b1;
            OP_IFZ:  begin cnt_wr_en_d = status[2];  add_offset_d = status[2];  end
            OP_IFNZ: begin cnt_wr_en_d = !status[2]; add_offset_d = !status[2]; end
            OP_IFEQ: begin cnt_wr_en_d = status[3];  add_offset_d = status[3];  end
            OP_IFST: begin cnt_wr_en_d = status[5];  add_offset_d = status[5];  end
            OP_IFGT: begin cnt_wr_en_d = status[4];  add_offset_d = status[4];  end
            default: reserved = 1'b1;
        endcase
    end

    // Reset masks the enables combinationally so nothing writes while rst_n is low.
    assign rd_en1     = rd_en1_d     & rst_n;
    assign rd_en2     = rd_en2_d     & rst_n;
    assign wr_en      = wr_en_d      & rst_n;
    assign cnt_wr_en  = cnt_wr_en_d  & rst_n;
    assign add_offset = add_offset_d & rst_n;
    assign stat_wr_en = stat_wr_en_d & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_op <= 1'b0;
        end else if (reserved) begin
            illegal_op <= 1'b1;
        end
    end

endmodule

// File: tb/tb_decoder.sv
// tb/tb_decoder.sv - directed self-checking bench for decoder
module tb_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instruction;
    logic [5:0]  status;
    logic [4:0]  opcode;
    logic [7:0]  param;
    logic [7:0]  literal_adr;
    logic [1:0]  rd_sel1, rd_sel2, wr_sel;
    logic        rd_en1, rd_en2, wr_en, sel_reg_in_alu_decoder;
    logic        cnt_wr_en, add_offset, stat_wr_en, stat_reg_in_alu_decoder;
    logic [5:0]  status_out;
    logic        illegal_op;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    decoder dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .status(status),
        .opcode(opcode), .param(param), .literal_adr(literal_adr),
        .rd_sel1(rd_sel1), .rd_sel2(rd_sel2), .rd_en1(rd_en1), .rd_en2(rd_en2),
        .wr_sel(wr_sel), .wr_en(wr_en), .sel_reg_in_alu_decoder(sel_reg_in_alu_decoder),
        .cnt_wr_en(cnt_wr_en), .add_offset(add_offset), .stat_wr_en(stat_wr_en),
        .stat_reg_in_alu_decoder(stat_reg_in_alu_decoder), .status_out(status_out),
        .illegal_op(illegal_op)
    );

    wire [12:0] ctrl_obs = {rd_sel1, rd_sel2, rd_en1, rd_en2, wr_sel, wr_en,
                            sel_reg_in_alu_decoder, cnt_wr_en, add_offset, stat_wr_en};

    function automatic logic [12:0] ctrl(input logic [1:0] rs1, input logic [1:0] rs2,
                                         input logic e1, input logic e2, input logic [1:0] ws,
                                         input logic we, input logic sr, input logic cw,
                                         input logic ao, input logic sw);
        return {rs1, rs2, e1, e2, ws, we, sr, cw, ao, sw};
    endfunction

    function automatic logic [15:0] rr(input logic [4:0] op, input logic [1:0] o1, input logic [1:0] o2);
        return {op, 1'b0, o1, 3'b000, o2, 3'b000};
    endfunction

    function automatic logic [15:0] imm(input logic [4:0] op, input logic [1:0] o1, input logic [7:0] p);
        return {op, 1'b0, o1, p};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic [15:0] i, input logic [5:0] s);
        @(negedge clk);
        instruction = i;
        status = s;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        instruction = 16'h0000;
        status = 6'b000000;
        #1;
        chk("reset_ctrl", 16'(ctrl_obs), 16'(ctrl(0,0,0,0,0,0,0,0,0,0)));
        chk("reset_illegal", 16'(illegal_op), 16'h0);
        chk("status_out", 16'(status_out), 16'h0);
        chk("stat_src", 16'(stat_reg_in_alu_decoder), 16'h1);
        @(negedge clk);
        rst_n = 1'b1;

        apply(16'h0000, 6'b000000);
        chk("nop", 16'(ctrl_obs), 16'(ctrl(0,0,0,0,0,0,0,0,0,0)));

        apply(rr(5'h01, 2'b01, 2'b10), 6'b0);
        chk("add", 16'(ctrl_obs), 16'(ctrl(1,2,1,1,1,1,1,0,0,1)));
        chk("add_opcode", 16'(opcode), 16'h0001);

        apply(rr(5'h06, 2'b10, 2'b11), 6'b0);
        chk("xor", 16'(ctrl_obs), 16'(ctrl(2,3,1,1,2,1,1,0,0,1)));

        apply(rr(5'h05, 2'b10, 2'b00), 6'b0);
        chk("not", 16'(ctrl_obs), 16'(ctrl(0,0,0,1,2,1,1,0,0,1)));

        apply(imm(5'h07, 2'b11, 8'h03), 6'b0);
        chk("shl", 16'(ctrl_obs), 16'(ctrl(3,0,1,0,3,1,1,0,0,1)));
        chk("shl_param", 16'(param), 16'h0003);

        apply(imm(5'h09, 2'b11, 8'hA5), 6'b0);
        chk("val", 16'(ctrl_obs), 16'(ctrl(0,0,0,0,3,1,0,0,0,0)));
        chk("val_param", 16'(param), 16'h00A5);

        apply(rr(5'h0A, 2'b00, 2'b10), 6'b0);
        chk("cmp", 16'(ctrl_obs), 16'(ctrl(0,2,1,1,0,0,0,0,0,1)));

        apply(imm(5'h10, 2'b00, 8'h3F), 6'b0);
        chk("goto", 16'(ctrl_obs), 16'(ctrl(0,0,0,0,0,0,0,1,0,0)));
        chk("goto_adr", 16'(literal_adr), 16'h003F);

        apply(imm(5'h11, 2'b00, 8'h10), 6'b000000);
        chk("ifz_0", 16'(ctrl_obs), 16'(ctrl(0,0,0,0,0,0,0,0,0,0)));
        apply(imm(5'h11, 2'b00, 8'h10), 6'b000100);
        chk("ifz_1", 16'(ctrl_obs), 16'(ctrl(0,0,0,0,0,0,0,1,1,0)));
        apply(imm(5'h12, 2'b00, 8'h10), 6'b000000);
        chk("ifnz_0", 16'(ctrl_obs), 16'(ctrl(0,0,0,0,0,0,0,1,1,0)));
        apply(imm(5'h12, 2'b00, 8'h10), 6'b000100);
        chk("ifnz_1", 16'(ctrl_obs), 16'(ctrl(0,0,0,0,0,0,0,0,0,0)));
        apply(imm(5'h13, 2'b00, 8'h10), 6'b110111);
        chk("ifeq_0", 16'(ctrl_obs), 16'(ctrl(0,0,0,0,0,0,0,0,0,0)));
        apply(imm(5'h13, 2'b00, 8'h10), 6'b001000);
        chk("ifeq_1", 16'(ctrl_obs), 16'(ctrl(0,0,0,0,0,0,0,1,1,0)));
        apply(imm(5'h14, 2'b00, 8'h10), 6'b011111);
        chk("ifst_0", 16'(ctrl_obs), 16'(ctrl(0,0,0,0,0,0,0,0,0,0)));
        apply(imm(5'h14, 2'b00, 8'h10), 6'b100000);
        chk("ifst_1", 16'(ctrl_obs), 16'(ctrl(0,0,0,0,0,0,0,1,1,0)));
        apply(imm(5'h15, 2'b00, 8'h10), 6'b101111);
        chk("ifgt_0", 16'(ctrl_obs), 16'(ctrl(0,0,0,0,0,0,0,0,0,0)));
        apply(imm(5'h15, 2'b00, 8'h10), 6'b010000);
        chk("ifgt_1", 16'(ctrl_obs), 16'(ctrl(0,0,0,0,0,0,0,1,1,0)));

        apply(rr(5'h0B, 2'b11, 2'b11), 6'b111111);
        chk("rsv_ctrl", 16'(ctrl_obs), 16'(ctrl(0,0,0,0,0,0,0,0,0,0)));
        chk("rsv_before_edge", 16'(illegal_op), 16'h0);
        @(posedge clk);
        #1;
        chk("rsv_after_edge", 16'(illegal_op), 16'h1);

        apply(rr(5'h01, 2'b01, 2'b10), 6'b0);
        chk("illegal_sticky", 16'(illegal_op), 16'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_add_ctrl", 16'(ctrl_obs), 16'(ctrl(1,2,0,0,1,0,1,0,0,0)));
        chk("rst_illegal", 16'(illegal_op), 16'h0);
        chk("rst_opcode", 16'(opcode), 16'h0001);
        rst_n = 1'b1;
        #1;
        chk("release_add", 16'(ctrl_obs), 16'(ctrl(1,2,1,1,1,1,1,0,0,1)));

        apply(rr(5'h1F, 2'b10, 2'b01), 6'b0);
        chk("rsv1f_ctrl", 16'(ctrl_obs), 16'(ctrl(0,0,0,0,0,0,0,0,0,0)));
        @(posedge clk);
        #1;
        chk("rsv1f_illegal", 16'(illegal_op), 16'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
